serial_paralelo_lane: RTL and testbench

//  Receive-side lane front end of the PHY. Converts one serial lane (MSB first, one bit per clk_32f)

---
 rtl/serial_paralelo_lane.sv | 112 +++++++++++
 tb/tb_serial_paralelo_lane.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo_lane.sv
// Receive-side lane front end: deserialises one MSB-first serial lane into bytes,
// hunts for byte alignment on COM symbols and declares the lane active once enough
// consecutive aligned COMs have been seen. Delivers bytes with strobe and valid flags.
module serial_paralelo_lane #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter logic [7:0] IDL        = 8'h7C,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] LOCK = 4'(LOCK_COUNT);

  state_t     state;
  state_t     state_next;
  logic [6:0] sr;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_next;
  logic [3:0] com_cnt;
  logic [3:0] com_cnt_next;
  logic [7:0] data_next;
  logic       valid_next;
  logic       strobe_next;
  logic [7:0] cand;
  logic       boundary;

  // The byte being completed on this edge is the seven held bits plus the incoming one.
  assign cand     = {sr, data_in};
  assign boundary = (bit_cnt == 3'd7);
  assign active   = (state == ACTIVE);

  // Next-state, alignment counters and output pulses for the lane FSM.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt + 3'd1;
    com_cnt_next = com_cnt;
    data_next    = data_out;
    valid_next   = 1'b0;
    strobe_next  = 1'b0;
    case (state)
      SEARCH: begin
        bit_cnt_next = bit_cnt;
        if (cand == COM) begin
          bit_cnt_next = 3'd0;
          com_cnt_next = 4'd1;
          state_next   = ALIGN;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (cand == COM) begin
            if (com_cnt + 4'd1 == LOCK) begin
              com_cnt_next = LOCK;
              state_next   = ACTIVE;
            end else begin
              com_cnt_next = com_cnt + 4'd1;
            end
          end else begin
            com_cnt_next = 4'd0;
            state_next   = SEARCH;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          data_next   = cand;
          strobe_next = 1'b1;
          valid_next  = (cand != COM) && (cand != IDL);
        end
      end
      default: begin
        state_next   = SEARCH;
        bit_cnt_next = 3'd0;
        com_cnt_next = 4'd0;
      end
    endcase
  end

  // Register all lane state on the bit clock; reset discards any partial byte.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state       <= SEARCH;
      sr          <= 7'd0;
      bit_cnt     <= 3'd0;
      com_cnt     <= 4'd0;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      state       <= state_next;
      sr          <= cand[6:0];
      bit_cnt     <= bit_cnt_next;
      com_cnt     <= com_cnt_next;
      data_out    <= data_next;
      valid_out   <= valid_next;
      byte_strobe <= strobe_next;
    end
  end

endmodule

// File: tb/tb_serial_paralelo_lane.sv
// Self-checking bench for serial_paralelo_lane: per-byte vector table plus hand-written
// sequences for reset, lock timing, offset alignment and reset in the middle of a byte.
module tb_serial_paralelo_lane;

  typedef struct {
    logic [7:0] din;
    logic       exp_active;
    logic       exp_strobe;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int   checks = 0;
  int   failures = 0;
  int   strobe_seen = 0;
  int   valid_seen = 0;
  vec_t vecs [24];

  serial_paralelo_lane dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  // Free-running bit clock.
  always #5 clk_32f = ~clk_32f;

  // Shift n bits (MSB first) into the lane, sampling outputs 1 time unit after each edge.
  task automatic applyStimulus(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      data_in = bits[i];
      @(posedge clk_32f);
      #1;
      if (byte_strobe) strobe_seen++;
      if (valid_out) valid_seen++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sendVector(input int idx);
    strobe_seen = 0;
    valid_seen  = 0;
    applyStimulus({9'd0, vecs[idx].din[7:1]}, 7);
    checkOutput($sformatf("mid_pulses[%0d]", idx), 8'(strobe_seen + valid_seen), 8'd0);
    applyStimulus({15'd0, vecs[idx].din[0]}, 1);
    checkOutput($sformatf("active[%0d]", idx), {7'd0, active}, {7'd0, vecs[idx].exp_active});
    checkOutput($sformatf("strobe[%0d]", idx), {7'd0, byte_strobe}, {7'd0, vecs[idx].exp_strobe});
    checkOutput($sformatf("valid[%0d]", idx), {7'd0, valid_out}, {7'd0, vecs[idx].exp_valid});
    checkOutput($sformatf("data[%0d]", idx), data_out, vecs[idx].exp_data);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // lock sequence: three BCs still aligning, the fourth is checked by hand
    vecs[0]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    // data after lock
    vecs[3]  = '{8'hBC, 1'b1, 1'b1, 1'b0, 8'hBC};
    vecs[4]  = '{8'h7C, 1'b1, 1'b1, 1'b0, 8'h7C};
    vecs[5]  = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5};
    vecs[6]  = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C};
    // broken lock then relock
    vecs[7]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[12] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[13] = '{8'hBC, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[14] = '{8'h11, 1'b1, 1'b1, 1'b1, 8'h11};
    vecs[15] = '{8'h11, 1'b1, 1'b1, 1'b1, 8'h11};
    // offset alignment: first COM comes from the bit prefix
    vecs[16] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[17] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[18] = '{8'hBC, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[19] = '{8'hE7, 1'b1, 1'b1, 1'b1, 8'hE7};
    // relock after mid-byte reset
    vecs[20] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[21] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[22] = '{8'hBC, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[23] = '{8'hBC, 1'b1, 1'b0, 1'b0, 8'h00};

    reset   = 1'b1;
    data_in = 1'b0;

    $display("[TB] reset held with random data");
    for (int c = 0; c < 3; c++) begin
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk_32f);
      #1;
      checkOutput("reset_flags", {5'd0, active, byte_strobe, valid_out}, 8'd0);
      checkOutput("reset_data", data_out, 8'h00);
    end
    reset = 1'b0;
    applyStimulus(16'h0000, 16);
    checkOutput("zeros_no_active", {7'd0, active}, 8'd0);

    $display("[TB] lock after junk bits");
    strobe_seen = 0;
    valid_seen  = 0;
    applyStimulus(16'b101, 3);
    for (int i = 0; i <= 2; i++) sendVector(i);
    strobe_seen = 0;
    valid_seen  = 0;
    applyStimulus(16'b1011110, 7);
    checkOutput("lock_not_yet", {7'd0, active}, 8'd0);
    applyStimulus(16'b0, 1);
    checkOutput("lock_active", {7'd0, active}, 8'd1);
    checkOutput("lock_no_pulses", 8'(strobe_seen + valid_seen), 8'd0);
    for (int i = 3; i <= 6; i++) sendVector(i);

    $display("[TB] broken lock");
    pulseReset();
    for (int i = 7; i <= 15; i++) sendVector(i);

    $display("[TB] offset alignment");
    pulseReset();
    applyStimulus(16'b0000_1011_1100, 12);
    checkOutput("offset_prefix_inactive", {7'd0, active}, 8'd0);
    for (int i = 16; i <= 19; i++) sendVector(i);

    $display("[TB] reset mid-byte while active");
    applyStimulus(16'b1010, 4);
    reset   = 1'b1;
    data_in = 1'b0;
    @(posedge clk_32f);
    #1;
    checkOutput("midreset_flags", {5'd0, active, byte_strobe, valid_out}, 8'd0);
    checkOutput("midreset_data", data_out, 8'h00);
    reset       = 1'b0;
    strobe_seen = 0;
    valid_seen  = 0;
    applyStimulus(16'b0101, 4);
    checkOutput("partial_no_strobe", 8'(strobe_seen + valid_seen), 8'd0);
    checkOutput("partial_inactive", {7'd0, active}, 8'd0);
    for (int i = 20; i <= 23; i++) sendVector(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
